// File: rtl/io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | io_pkg : register offsets and constants shared by io_hub       |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package io_pkg;

  localparam logic [2:0]  c_off_sw          = 3'd0;
  localparam logic [2:0]  c_off_edge        = 3'd1;
  localparam logic [2:0]  c_off_led         = 3'd2;
  localparam logic [2:0]  c_off_mask        = 3'd3;
  localparam logic [2:0]  c_off_status      = 3'd4;

  localparam logic [15:0] c_version         = 16'h0001;
  localparam logic [31:0] c_default_io_base = 32'hFFFF_FC00;

endpackage
`default_nettype wire

// File: rtl/io_debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | io_debounce_bit : 2-flop synchroniser + 3-sample debouncer     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module io_debounce_bit
  import io_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic deb
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] hist_q, hist_d;
  logic       deb_q, deb_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    hist_d = hist_q;
    deb_d  = deb_q;
    if (tick) begin
      hist_d = {hist_q[1:0], sync_q[1]};
      // disagreeing samples leave the debounced value untouched
      if (&hist_d) begin
        deb_d = 1'b1;
      end else if (~|hist_d) begin
        deb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      deb_q  <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule
`default_nettype wire

// File: rtl/io_hub.sv
`default_nettype none
// +----------------------------------------------------------------+
// | io_hub : debounced inputs, edge capture/irq and LED register   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module io_hub
  import io_pkg::*;
#(
  parameter int          IN_WIDTH        = 24,
  parameter int          LED_WIDTH       = 24,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] IO_BASE         = c_default_io_base
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  button_in,
  output logic [LED_WIDTH-1:0] led_out,
  input  logic [31:0]          addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  output logic                 ready,
  output logic                 irq
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]  deb_prev_q, deb_prev_d;
  logic [IN_WIDTH-1:0]  edge_q, edge_d;
  logic [IN_WIDTH-1:0]  mask_q, mask_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 ready_q, ready_d;
  logic                 irq_q, irq_d;

  logic                 w_tick;
  logic [IN_WIDTH-1:0]  w_deb;
  logic [IN_WIDTH-1:0]  w_edge_clr;
  logic                 w_hit;
  logic [2:0]           w_off;
  logic                 w_rd;
  logic                 w_wr;
  logic [31:0]          w_rd_word;
  logic                 unused_bits;

  assign w_tick      = (cnt_q == c_cnt_last);
  assign w_hit       = (addr[31:5] == IO_BASE[31:5]);
  assign w_off       = addr[4:2];
  assign w_rd        = rd_en && w_hit;
  assign w_wr        = wr_en && w_hit;
  assign unused_bits = ^{addr[1:0], wr_data};

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_deb
    io_debounce_bit u_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick),
      .din  (button_in[i]),
      .deb  (w_deb[i])
    );
  end

  always_comb begin
    w_rd_word = '0;
    case (w_off)
      c_off_sw:     w_rd_word[IN_WIDTH-1:0]  = w_deb;
      c_off_edge:   w_rd_word[IN_WIDTH-1:0]  = edge_q;
      c_off_led:    w_rd_word[LED_WIDTH-1:0] = led_q;
      c_off_mask:   w_rd_word[IN_WIDTH-1:0]  = mask_q;
      c_off_status: w_rd_word = {c_version, 8'(IN_WIDTH), 8'(LED_WIDTH)};
      default:      w_rd_word = '0;
    endcase
  end

  always_comb begin
    cnt_d      = w_tick ? '0 : cnt_q + CNT_W'(1);
    deb_prev_d = w_deb;
    w_edge_clr = (w_wr && (w_off == c_off_edge)) ? wr_data[IN_WIDTH-1:0] : '0;
    // a rising edge arriving with a W1C of the same bit survives the clear
    edge_d     = (edge_q & ~w_edge_clr) | (w_deb & ~deb_prev_q);
    mask_d     = (w_wr && (w_off == c_off_mask)) ? wr_data[IN_WIDTH-1:0] : mask_q;
    led_d      = (w_wr && (w_off == c_off_led)) ? wr_data[LED_WIDTH-1:0] : led_q;
    irq_d      = |(edge_q & mask_q);
    ready_d    = w_rd;
    rd_data_d  = w_rd ? w_rd_word : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      deb_prev_q <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      led_q      <= '0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      deb_prev_q <= deb_prev_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      led_q      <= led_d;
      irq_q      <= irq_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign led_out = led_q;
  assign rd_data = rd_data_q;
  assign ready   = ready_q;
  assign irq     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_io_hub.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_io_hub : directed and random checks of io_hub vs a model    |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_io_hub;

  localparam int          IN_W  = 24;
  localparam int          LED_W = 24;
  localparam int          D     = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_FC00;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic [IN_W-1:0]   button_in = '0;
  logic [LED_W-1:0]  led_out;
  logic [31:0]       addr      = '0;
  logic              rd_en     = 1'b0;
  logic              wr_en     = 1'b0;
  logic [31:0]       wr_data   = '0;
  logic [31:0]       rd_data;
  logic              ready;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

  io_hub #(
    .IN_WIDTH        (IN_W),
    .LED_WIDTH       (LED_W),
    .DEBOUNCE_CYCLES (D),
    .IO_BASE         (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button_in (button_in),
    .led_out   (led_out),
    .addr      (addr),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ready     (ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: raw input samples, tick samples, debounced value,
  // register contents and the registered bus/irq outputs.
  logic [IN_W-1:0]  m_b1, m_b2, m_s0, m_s1, m_s2;
  logic [IN_W-1:0]  m_deb, m_deb_prev, m_edge, m_mask;
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_rdata;
  logic             m_ready, m_irq;
  int               m_n;

  function automatic logic [31:0] m_reg(input int off);
    case (off)
      0:       return {8'h00, m_deb};
      1:       return {8'h00, m_edge};
      2:       return {8'h00, m_led};
      3:       return {8'h00, m_mask};
      4:       return 32'h0001_1818;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_b1 = '0; m_b2 = '0; m_s0 = '0; m_s1 = '0; m_s2 = '0;
    m_deb = '0; m_deb_prev = '0; m_edge = '0; m_mask = '0; m_led = '0;
    m_rdata = '0; m_ready = 1'b0; m_irq = 1'b0; m_n = 0;
  endtask

  task automatic model_step();
    logic            hit;
    int              off;
    logic [IN_W-1:0] rise;
    logic [IN_W-1:0] clr;
    hit  = ((addr >> 5) == (BASE >> 5));
    off  = int'((addr >> 2) & 32'h7);
    rise = m_deb & ~m_deb_prev;
    clr  = (wr_en && hit && off == 1) ? wr_data[IN_W-1:0] : '0;
    m_ready = rd_en && hit;
    m_rdata = (rd_en && hit) ? m_reg(off) : 32'h0;
    m_irq   = |(m_edge & m_mask);
    m_edge  = (m_edge & ~clr) | rise;
    if (wr_en && hit && off == 2) m_led  = wr_data[LED_W-1:0];
    if (wr_en && hit && off == 3) m_mask = wr_data[IN_W-1:0];
    m_deb_prev = m_deb;
    if ((m_n % D) == D - 1) begin
      m_s2 = m_s1; m_s1 = m_s0; m_s0 = m_b2;
      m_deb = (m_deb | (m_s0 & m_s1 & m_s2)) & (m_s0 | m_s1 | m_s2);
    end
    m_b2 = m_b1;
    m_b1 = button_in;
    m_n++;
  endtask

  task automatic cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    rd_en = rd; wr_en = wr; addr = a; wr_data = wd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("ready", {31'h0, ready}, {31'h0, m_ready});
    check("rd_data", rd_data, m_rdata);
    check("led_out", {8'h00, led_out}, {8'h00, m_led});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] off);
    cycle(1'b1, 1'b0, BASE + off, 32'h0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    cycle(1'b0, 1'b1, BASE + off, d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_led", {8'h00, led_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic        found;
    logic [31:0] a;
    int          r;
    int          idx;

    @(negedge clk);
    do_reset();
    rd(0);
    check("reset_sw", rd_data, 32'h0);

    // steady button 3: debounced, edge captured, irq after mask
    button_in[3] = 1'b1;
    idle(13);
    rd(0);
    check("sw3_set", rd_data, 32'h8);
    rd(4);
    check("edge3_set", rd_data, 32'h8);
    wr(12, 32'h8);
    idle(1);
    check("irq_mask3", {31'h0, irq}, 32'h1);

    // bouncing bit 0 never settles
    for (int i = 0; i < 40; i++) begin
      button_in[0] = ((i / 3) % 2) == 1;
      idle(1);
    end
    button_in[0] = 1'b0;
    rd(0);
    check("sw0_bounce", rd_data, 32'h8);
    rd(4);
    check("edge0_bounce", rd_data, 32'h8);

    // LED write and read-back latency
    wr(8, 32'h00A5_5A5A);
    check("led_next", {8'h00, led_out}, 32'h00A5_5A5A);
    rd(8);
    check("led_rd_ready", {31'h0, ready}, 32'h1);
    check("led_rd", rd_data, 32'h00A5_5A5A);
    idle(1);
    check("ready_once", {31'h0, ready}, 32'h0);

    // set-wins W1C collision, then full clear
    wr(4, 32'hFFFF_FFFF);
    wr(12, 32'hF);
    button_in[1:0] = 2'b11;
    idle(16);
    rd(4);
    check("edge_03", rd_data, 32'h3);
    button_in[0] = 1'b0;
    idle(16);
    button_in[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      if (m_deb[0] && !m_deb_prev[0]) begin
        wr(4, 32'h1);
        found = 1'b1;
      end else begin
        idle(1);
      end
    end
    check("collision_seen", {31'h0, found}, 32'h1);
    idle(1);
    rd(4);
    check("edge_set_wins", rd_data, 32'h3);
    wr(4, 32'h3);
    idle(1);
    check("irq_clear", {31'h0, irq}, 32'h0);
    rd(4);
    check("edge_clear", rd_data, 32'h0);

    // status, reserved and out-of-window accesses
    rd(16);
    check("status", rd_data, 32'h0001_1818);
    rd(20);
    check("reserved", rd_data, 32'h0);
    cycle(1'b1, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF);
    check("miss_ready", {31'h0, ready}, 32'h0);
    rd(8);
    check("miss_led", rd_data, 32'h00A5_5A5A);

    // reset right after a read returns
    wr(4, 32'hFFFF_FFFF);
    wr(12, 32'h0);
    rd(8);
    do_reset();
    idle(20);
    check("led_after_rst", {8'h00, led_out}, 32'h0);
    check("irq_after_rst", {31'h0, irq}, 32'h0);
    rd(4);
    check("edge_after_rst", rd_data, 32'hB);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        button_in = IN_W'($urandom);
      end else if (r < 12) begin
        idx = int'($urandom_range(0, IN_W - 1));
        button_in[idx] = ~button_in[idx];
      end
      a = BASE + 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
